iter_divider: RTL and testbench
===============================

# iter_divider

Multi-cycle restoring integer divider for the CPU execute stage, producing quotient and remainder one bit per cycle. It is the subtract-and-shift counterpart to the parallel-prefix adder datapath. It accepts one operation at a time through a valid/ready request port and returns results through a valid/ready response port.

## Interface
- WIDTH, 64, operand/result width in bits (power of two, ≥8)
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- dividend  in  WIDTH  numerator
- divisor  in  WIDTH  denominator
- is_signed  in  1  two's-complement operation (honoured only with DIV_SIGNED_EN)
- flush  in  1  abort current operation
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- quotient  out  WIDTH  result quotient
- remainder  out  WIDTH  result remainder
- div_by_zero  out  1  flag, valid with out_valid

## Operation
- States: IDLE, CALC, DONE. Reset → IDLE.
- in_ready = (state == IDLE). Requests are never accepted in CALC or DONE.
- IDLE + accept, divisor ≠ 0 → CALC. Latch |dividend|, |divisor|, result signs, step counter = WIDTH−1.
- IDLE + accept, divisor == 0 → DONE directly:
  - quotient = all ones, remainder = dividend, div_by_zero = 1.
- CALC, each cycle:
  - partial = {rem[WIDTH−2:0], dvd_msb}; shift the dividend register left by one.
  - If partial ≥ divisor: rem = partial − divisor and the quotient bit is 1. Otherwise rem = partial and the bit is 0.
  - The subtraction is WIDTH+1 bits wide; its borrow decides the bit.
  - At counter == 0 → DONE; the sign fix-up is applied on entry to DONE.
- Sign fix-up (signed only):
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Overflow case MIN/−1 yields quotient = MIN, remainder = 0, with no special path: the magnitude arithmetic wraps to this result.
- DONE: out_valid = 1. Outputs are held stable while out_ready = 0. On out_ready → IDLE.
- flush in any state → IDLE next cycle, out_valid = 0, result discarded. flush has priority over in_valid and out_ready in the same cycle.
- Reset mid-operation: immediate IDLE, all outputs take their reset values asynchronously.

## Timing
- Reset values:
  - out_valid = 0, quotient = 0, remainder = 0, div_by_zero = 0.
  - in_ready = 1, since state is IDLE.
- Normal latency: accept at edge N; out_valid asserts after edge N+WIDTH+1 (WIDTH CALC cycles plus one DONE entry).
- Divide-by-zero latency: out_valid after edge N+1.
- Throughput: one operation per WIDTH+2 cycles with out_ready held high. A new request can be accepted in the cycle after the response handshake.
- Outputs are registered; there are no combinational paths from in_* to out_*.

## Configuration
- DIV_SIGNED_EN defined:
  - is_signed selects two's-complement semantics.
  - Operand absolute-value logic and result negation logic are present.
- DIV_SIGNED_EN undefined:
  - is_signed is ignored and all operations are unsigned.
  - No negation logic is synthesised.
  - Divide-by-zero behaviour is unchanged.

## Structure
- Package div_pkg: state enum (IDLE/CALC/DONE) and the default WIDTH constant.
- Sub-module div_step: combinational one-bit restoring step.
  - Inputs: partial remainder, divisor.
  - Outputs: next remainder, quotient bit.
  - Instantiated once inside iter_divider.

## Test plan
- Unsigned 100/7, out_ready = 1 → quotient 14, remainder 2, div_by_zero 0, out_valid exactly WIDTH+1 cycles after accept.
- 5/0 → quotient 0xFFFF_FFFF_FFFF_FFFF, remainder 5, div_by_zero 1, out_valid one cycle after accept.
- DIV_SIGNED_EN, is_signed = 1, −7/2 → quotient −3, remainder −1. 0x8000_0000_0000_0000 / −1 → quotient 0x8000_0000_0000_0000, remainder 0. Without the macro, −7/2 returns the unsigned result.
- Backpressure: out_ready low for 10 cycles in DONE → outputs stable, in_ready 0 throughout. Raise out_ready → IDLE, in_ready 1 next cycle.
- flush at CALC cycle 20 → out_valid never asserts. A next request of 9/3 → quotient 3, remainder 0, full latency.
- rst asserted mid-CALC → outputs return to reset values without waiting for a clock edge; the next request completes normally.

Source files
------------

// File: rtl/iter_divider_pkg.sv
// Shared types for the iterative restoring divider: FSM state encoding and default width.
package div_pkg;

  localparam int DEF_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/iter_divider_if.sv
// Request/response bundle for iter_divider; master is the issuing stage, slave is the divider.
interface iter_divider_if #(
  parameter int WIDTH = 64
);
  // A request transfers on a clock edge where in_valid && in_ready; a response transfers
  // on an edge where out_valid && out_ready. Neither side may make valid wait on ready.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             is_signed;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, is_signed, flush, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, is_signed, flush, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/iter_divider_div_step.sv
// One restoring-division step: trial subtract, keep the difference when it does not borrow.
module div_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] partial,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] diff;

  // One extra bit so the borrow out of the subtraction is the comparison result.
  assign diff     = {1'b0, partial} - {1'b0, divisor};
  assign q_bit    = ~diff[WIDTH];
  assign rem_next = q_bit ? diff[WIDTH-1:0] : partial;

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider, one quotient bit per cycle.
// Define DIV_SIGNED_EN to honour is_signed (two's-complement operands and results).
module iter_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  iter_divider_if.slave   bus,
  output state_t          dbg_state
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd, dsr, rem;
  logic [WIDTH-1:0] q_out, r_out;
  logic             dbz;
  logic             accept, step_q;
  logic [WIDTH-1:0] partial, step_rem;
  logic [WIDTH-1:0] op_a, op_b, fin_q, fin_r;

  assign accept  = bus.in_valid && (state == IDLE) && !bus.flush;
  assign partial = {rem[WIDTH-2:0], dvd[WIDTH-1]};

  div_step #(.WIDTH(WIDTH)) u_step (
    .partial  (partial),
    .divisor  (dsr),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

`ifdef DIV_SIGNED_EN
  logic a_neg, b_neg, neg_q, neg_r;

  assign a_neg = bus.is_signed & bus.dividend[WIDTH-1];
  assign b_neg = bus.is_signed & bus.divisor[WIDTH-1];
  assign op_a  = a_neg ? -bus.dividend : bus.dividend;
  assign op_b  = b_neg ? -bus.divisor  : bus.divisor;
  // MIN/-1 needs no special case: |MIN| wraps to MIN and negating it gives MIN again.
  assign fin_q = neg_q ? -{dvd[WIDTH-2:0], step_q} : {dvd[WIDTH-2:0], step_q};
  assign fin_r = neg_r ? -step_rem : step_rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
    end
  end
`else
  logic unused_is_signed;

  assign unused_is_signed = bus.is_signed;
  assign op_a  = bus.dividend;
  assign op_b  = bus.divisor;
  assign fin_q = {dvd[WIDTH-2:0], step_q};
  assign fin_r = step_rem;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (accept) state_next = (bus.divisor == '0) ? DONE : CALC;
      end
      CALC: begin
        if (cnt == '0) state_next = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (bus.flush) state_next = IDLE;
  end

  // The dividend register doubles as the quotient: one bit shifts out, one shifts in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      dvd   <= '0;
      dsr   <= '0;
      rem   <= '0;
      q_out <= '0;
      r_out <= '0;
      dbz   <= 1'b0;
    end else if (accept) begin
      dvd <= op_a;
      dsr <= op_b;
      rem <= '0;
      cnt <= CW'(WIDTH - 1);
      dbz <= (bus.divisor == '0);
      if (bus.divisor == '0) begin
        q_out <= '1;
        r_out <= bus.dividend;
      end
    end else if (state == CALC && !bus.flush) begin
      dvd <= {dvd[WIDTH-2:0], step_q};
      rem <= step_rem;
      cnt <= cnt - 1'b1;
      if (cnt == '0) begin
        q_out <= fin_q;
        r_out <= fin_r;
      end
    end
  end

  assign bus.quotient    = q_out;
  assign bus.remainder   = r_out;
  assign bus.div_by_zero = dbz;
  assign dbg_state       = state;

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider: directed vectors, latency, backpressure, flush and reset.
module tb_iter_divider;
  import div_pkg::*;

  localparam int W  = DEF_WIDTH;
  localparam int EW = 2 * W + 1;

  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;
  int     cyc = 0;

  iter_divider_if #(.WIDTH(W)) bus ();

  iter_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [EW-1:0] exp_q[$];
  int            lat_q[$];
  int            acc_q[$];
  int            errors = 0;
  int            checks = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  logic          prev_valid = 1'b0;
  int            mon_a, mon_l;
  logic [EW-1:0] mon_e;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && !prev_valid) begin
        if (acc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got out_valid=1 expected no response at cycle %0d", cyc);
        end else begin
          mon_a = acc_q.pop_front();
          mon_l = lat_q.pop_front();
          check("latency", W'(cyc - mon_a), W'(mon_l));
        end
      end
      if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("quotient", bus.quotient, mon_e[EW-1:W+1]);
        check("remainder", bus.remainder, mon_e[W:1]);
        check("div_by_zero", W'(bus.div_by_zero), W'(mon_e[0]));
      end
    end
    prev_valid = bus.out_valid;
  end

  // Driver tasks: all start and end at posedge+1
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                       input bit track);
    bus.dividend  = a;
    bus.divisor   = b;
    bus.is_signed = sgn;
    bus.in_valid  = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.in_ready) break;
    end
    check("accept", W'(bus.in_ready), W'(1));
    if (track) acc_q.push_back(cyc);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [W-1:0] b, input logic [W-1:0] eq,
                          input logic [W-1:0] er, input logic edz);
    exp_q.push_back({eq, er, edz});
    lat_q.push_back((b == '0) ? 1 : W + 1);
  endtask

  task automatic drain();
    for (int n = 0; n < 300; n++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check("drain", W'(exp_q.size()), W'(0));
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    push_exp(b, eq, er, edz);
    issue(a, b, sgn, 1'b1);
    drain();
  endtask

  localparam logic [W-1:0] ONES = '1;
  localparam logic [W-1:0] MIN  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] M7   = 64'hFFFF_FFFF_FFFF_FFF9;
  localparam logic [W-1:0] M2   = 64'hFFFF_FFFF_FFFF_FFFE;
  localparam logic [W-1:0] M3   = 64'hFFFF_FFFF_FFFF_FFFD;

  bit saw_valid;

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.is_signed = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", W'(bus.out_valid), W'(0));
    check("rst_in_ready", W'(bus.in_ready), W'(1));
    check("rst_quotient", bus.quotient, '0);
    check("rst_remainder", bus.remainder, '0);
    check("rst_dbz", W'(bus.div_by_zero), W'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Unsigned directed vectors
    do_op(64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 1'b0);
    do_op(64'd5, 64'd0, 1'b0, ONES, 64'd5, 1'b0 | 1'b1);
    do_op(64'd0, 64'd5, 1'b0, 64'd0, 64'd0, 1'b0);
    do_op(64'd123456789, 64'd1000, 1'b0, 64'd123456, 64'd789, 1'b0);
    do_op(ONES, 64'd1, 1'b0, ONES, 64'd0, 1'b0);
    do_op(ONES, ONES, 1'b0, 64'd1, 64'd0, 1'b0);
    do_op(ONES, 64'h1_0000_0000, 1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0);
    do_op(MIN, 64'hC000_0000_0000_0000, 1'b0, 64'd0, MIN, 1'b0);

    // is_signed requests: two's-complement only when the signed build is selected
`ifdef DIV_SIGNED_EN
    do_op(M7, 64'd2, 1'b1, M3, ONES, 1'b0);
    do_op(MIN, ONES, 1'b1, MIN, 64'd0, 1'b0);
    do_op(64'd7, M2, 1'b1, M3, 64'd1, 1'b0);
    do_op(M7, M2, 1'b1, 64'd3, ONES, 1'b0);
    do_op(M7, 64'd0, 1'b1, ONES, M7, 1'b1);
`else
    do_op(M7, 64'd2, 1'b1, 64'h7FFF_FFFF_FFFF_FFFC, 64'd1, 1'b0);
    do_op(MIN, ONES, 1'b1, 64'd0, MIN, 1'b0);
    do_op(64'd7, M2, 1'b1, 64'd0, 64'd7, 1'b0);
    do_op(M7, M2, 1'b1, 64'd0, M7, 1'b0);
    do_op(M7, 64'd0, 1'b1, ONES, M7, 1'b1);
`endif
    do_op(M7, 64'd2, 1'b0, 64'h7FFF_FFFF_FFFF_FFFC, 64'd1, 1'b0);

    // Backpressure: hold DONE for 10 cycles
    bus.out_ready = 1'b0;
    push_exp(64'd10, 64'd100, 64'd0, 1'b0);
    issue(64'd1000, 64'd10, 1'b0, 1'b1);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
    check("bp_valid_seen", W'(bus.out_valid), W'(1));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_out_valid", W'(bus.out_valid), W'(1));
      check("bp_in_ready", W'(bus.in_ready), W'(0));
      check("bp_quotient", bus.quotient, 64'd100);
      check("bp_remainder", bus.remainder, 64'd0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_release_in_ready", W'(bus.in_ready), W'(1));
    check("bp_release_out_valid", W'(bus.out_valid), W'(0));
    check("bp_drained", W'(exp_q.size()), W'(0));
    @(posedge clk);
    #1;

    // Flush in the 20th CALC cycle
    issue(64'd50, 64'd5, 1'b0, 1'b0);
    repeat (19) begin
      @(posedge clk);
      #1;
    end
    check("flush_pre_state", W'(dbg_state), W'(CALC));
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("flush_state", W'(dbg_state), W'(IDLE));
    saw_valid = 1'b0;
    repeat (W + 5) begin
      @(negedge clk);
      if (bus.out_valid) saw_valid = 1'b1;
    end
    check("flush_no_valid", W'(saw_valid), W'(0));
    @(posedge clk);
    #1;
    do_op(64'd9, 64'd3, 1'b0, 64'd3, 64'd0, 1'b0);

    // Asynchronous reset mid-CALC
    issue(64'd77, 64'd7, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_out_valid", W'(bus.out_valid), W'(0));
    check("arst_in_ready", W'(bus.in_ready), W'(1));
    check("arst_quotient", bus.quotient, '0);
    check("arst_remainder", bus.remainder, '0);
    check("arst_dbz", W'(bus.div_by_zero), W'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_op(64'd200, 64'd9, 1'b0, 64'd22, 64'd2, 1'b0);

    repeat (5) @(posedge clk);
    check("final_queue", W'(exp_q.size()), W'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
